seq_det_arbiter: RTL and testbench
==================================

Name: seq_det_arbiter

Overview:
- Round-robin arbiter sharing one serial sequence-detector FSM (single-bit input w, Moore output b) among NREQ requesters, each owning a serial bit stream.
- Grants one requester per burst, forwards its bit stream to the shared detector's w input, and captures the detector's b output into per-requester hit flags.
- Issues a one-cycle detector clear between bursts so no detector state carries over from one requester to the next.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- BURST_LEN, 8, maximum cycles a grant is held; legal range 2..255.
- CNT_W, 8, width of the burst counter; must satisfy 2**CNT_W > BURST_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  per-requester request, level.
- w_in  input  NREQ  per-requester serial data bit.
- det_b  input  1  Moore output b of the shared detector.
- gnt  output  NREQ  one-hot grant, registered.
- det_w  output  1  bit driven to the detector's w input, registered.
- det_clr  output  1  one-cycle detector clear pulse, registered.
- hit  output  NREQ  sticky per-requester "detector reported b=1 during own burst".
- hit_clr  input  NREQ  per-bit clear of hit.
- busy  output  1  high in RUN or FLUSH.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: gnt=0, det_w=0, det_clr=1, hit=0, busy=0, state=IDLE, rr_ptr=NREQ-1, cnt=0.
- det_clr holds 1 throughout reset and for the first cycle after release, so the detector starts from its initial state.
- States:
  - IDLE: arbitration; gnt=0.
  - RUN: grant held.
  - FLUSH: one-cycle detector clear.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set req bit searching upward from rr_ptr+1 (mod NREQ).
  - Next cycle: gnt=onehot(sel), cnt=0, go to RUN.
- RUN, every cycle:
  - det_w <= w_in[sel] (one-cycle latency from w_in to det_w).
  - cnt increments.
  - If det_b==1 in any RUN cycle after the first, set hit[sel].
- RUN exit: when cnt==BURST_LEN-1 or req[sel]==0, go to FLUSH. On that edge: gnt<=0, det_clr<=1, rr_ptr<=sel.
- FLUSH: det_clr=1 for exactly one cycle, det_w=0, then go to IDLE.
- Minimum gap between grants is 2 cycles (FLUSH + IDLE).
- Simultaneous events:
  - hit set and hit_clr on the same bit in the same cycle: set wins.
  - req dropping in the same cycle as cnt reaching BURST_LEN-1 is a single exit to FLUSH, not two.
- A requester whose req drops mid-burst loses the grant in the next cycle and its remaining bits are not forwarded.
- Reset asserted mid-burst: immediate return to reset values, including det_clr=1.
- gnt is always one-hot or zero; NREQ=1 is illegal.

Optional Feature:
- SEQ_DET_ARB_FIXED_PRIO_EN
  - Defined: IDLE selects the lowest-index set req bit (req[0] highest priority); rr_ptr is not used.
  - Undefined: round-robin as above.

Decomposition:
- Package seq_det_arb_pkg:
  - state encoding: IDLE=2'b00, RUN=2'b01, FLUSH=2'b10;
  - default BURST_LEN and NREQ constants.
- One sub-module, rr_pick:
  - Combinational; inputs req and rr_ptr, outputs the one-hot select and its index.
  - The fixed-priority variant lives inside it under the macro.

Test Plan:
- Single requester: req=4'b0001 held, w_in[0]=1,0,0,... → gnt=0001 one cycle after request; det_w follows w_in[0] delayed one cycle; gnt drops after 8 RUN cycles; det_clr=1 for 1 cycle; regrant 2 cycles later.
- All requesting: req=4'b1111 from reset → grant order 0001,0010,0100,1000,0001; each burst 8 cycles; 2-cycle gaps between bursts.
- Early release: req[2] drops on RUN cycle 3 → gnt=0 next cycle; FLUSH; then IDLE grants next requester.
- Hit capture: during requester 1's burst drive det_b=1 on cycle 4 → hit=4'b0010 until hit_clr[1]=1; hit_clr and det_b=1 in the same cycle → hit stays 1.
- Reset mid-burst: rst=1 on RUN cycle 5 → gnt=0 and det_clr=1 asynchronously; hit=0; after release the first grant goes to requester 0.
- SEQ_DET_ARB_FIXED_PRIO_EN defined, req=4'b1010 held → grants 0010 repeatedly; requester 3 is never granted.

Source files
------------

// File: rtl/seq_det_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_arb_pkg
// Description : Shared constants and the state encoding for the round-robin
//               arbiter that time-shares one serial sequence detector.
//               Configuration macro used by the arbiter:
//                   SEQ_DET_ARB_FIXED_PRIO_EN - fixed priority (req[0] first)
//                                               instead of round-robin.
// Contents    : c_NREQ_DEFAULT, c_BURST_LEN_DEFAULT, c_CNT_W_DEFAULT,
//               state_t and the c_ST_* state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_arb_pkg;

    // Default build configuration.
    localparam int c_NREQ_DEFAULT      = 4;
    localparam int c_BURST_LEN_DEFAULT = 8;
    localparam int c_CNT_W_DEFAULT     = 8;

    // Arbiter state encoding.
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'b00;  // arbitration, no grant
    localparam state_t c_ST_RUN   = 2'b01;  // grant held, bits forwarded
    localparam state_t c_ST_FLUSH = 2'b10;  // one-cycle detector clear

endpackage : seq_det_arb_pkg
`default_nettype wire

// File: rtl/seq_det_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational requester selection for seq_det_arbiter.
//               Default: round-robin, searching upward from rr_ptr+1 with
//               wrap-around at NREQ.
//               With SEQ_DET_ARB_FIXED_PRIO_EN defined: the lowest-index set
//               request wins and rr_ptr is ignored.
// Ports       : req      in   NREQ   request vector
//               rr_ptr   in   IDX_W  index of the last granted requester
//               sel_vld  out  1      at least one request is set
//               sel_oh   out  NREQ   one-hot selection (zero if none)
//               sel_idx  out  IDX_W  index of the selected requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import seq_det_arb_pkg::*;
#(
    parameter int NREQ  = c_NREQ_DEFAULT,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             sel_vld,
    output logic [NREQ-1:0]  sel_oh,
    output logic [IDX_W-1:0] sel_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

`ifdef SEQ_DET_ARB_FIXED_PRIO_EN

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end

`else

    // One extra bit holds rr_ptr + k before the wrap; rr_ptr <= NREQ-1 and
    // k <= NREQ, so a single conditional subtract is enough to wrap, which
    // also keeps non-power-of-two NREQ correct.
    logic [IDX_W:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NREQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NREQ);
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

`endif

    always_comb begin
        sel_oh = '0;
        if (w_found) begin
            sel_oh[w_idx] = 1'b1;
        end
    end

    assign sel_vld = w_found;
    assign sel_idx = w_idx;

endmodule : rr_pick
`default_nettype wire

// File: rtl/seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_arbiter
// Description : Shares one serial sequence detector (input w, Moore output b)
//               among NREQ requesters. One requester is granted per burst of
//               at most BURST_LEN cycles; its serial bit is forwarded to the
//               detector and any b=1 reported during its burst sets its
//               sticky hit flag. A one-cycle detector clear separates bursts
//               so no detector state leaks between requesters.
//               Configuration macro:
//                   SEQ_DET_ARB_FIXED_PRIO_EN - fixed priority, req[0] highest
//                                               (default: round-robin).
// Ports       : clk      in   1     rising-edge clock
//               rst      in   1     asynchronous reset, active-high
//               req      in   NREQ  per-requester request (level)
//               w_in     in   NREQ  per-requester serial data bit
//               det_b    in   1     detector Moore output b
//               gnt      out  NREQ  one-hot grant, registered
//               det_w    out  1     detector w input, registered
//               det_clr  out  1     detector clear pulse, registered
//               hit      out  NREQ  sticky per-requester hit flags
//               hit_clr  in   NREQ  per-bit clear of hit (set wins)
//               busy     out  1     high in RUN or FLUSH
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_arbiter
    import seq_det_arb_pkg::*;
#(
    parameter int NREQ      = c_NREQ_DEFAULT,
    parameter int BURST_LEN = c_BURST_LEN_DEFAULT,
    parameter int CNT_W     = c_CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] w_in,
    input  logic            det_b,
    output logic [NREQ-1:0] gnt,
    output logic            det_w,
    output logic            det_clr,
    output logic [NREQ-1:0] hit,
    input  logic [NREQ-1:0] hit_clr,
    output logic            busy
);

    localparam int                 c_IDX_W      = $clog2(NREQ);
    localparam logic [CNT_W-1:0]   c_CNT_LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_RR_PTR_RST = c_IDX_W'(NREQ - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic               r_det_w;
    logic               r_det_clr;
    logic [NREQ-1:0]    r_hit;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_sel;
    logic [CNT_W-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [NREQ-1:0]    w_gnt_nxt;
    logic               w_det_w_nxt;
    logic               w_det_clr_nxt;
    logic [NREQ-1:0]    w_hit_set;
    logic [NREQ-1:0]    w_hit_nxt;
    logic [c_IDX_W-1:0] w_rr_ptr_nxt;
    logic [c_IDX_W-1:0] w_sel_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_run_exit;

    // Selector outputs
    logic               w_pick_vld;
    logic [NREQ-1:0]    w_pick_oh;
    logic [c_IDX_W-1:0] w_pick_idx;

    rr_pick #(
        .NREQ    (NREQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .sel_vld (w_pick_vld),
        .sel_oh  (w_pick_oh),
        .sel_idx (w_pick_idx)
    );

    // Burst ends on the length limit or when the owner withdraws; both
    // conditions together still produce a single exit.
    assign w_run_exit = (r_cnt == c_CNT_LAST) || !req[r_sel];

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_det_w_nxt   = 1'b0;
        w_det_clr_nxt = 1'b0;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_hit_set     = '0;

        case (r_state)
            c_ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_vld) begin
                    w_state_nxt = c_ST_RUN;
                    w_gnt_nxt   = w_pick_oh;
                    w_sel_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_RUN: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // The detector output in the first RUN cycle still reflects
                // the cleared state, so only later cycles count as hits.
                if (det_b && (r_cnt != '0)) begin
                    w_hit_set = r_gnt;
                end
                if (w_run_exit) begin
                    // Bits arriving on the exit edge belong to a burst that
                    // is being closed, so they are not forwarded.
                    w_state_nxt   = c_ST_FLUSH;
                    w_gnt_nxt     = '0;
                    w_det_clr_nxt = 1'b1;
                    w_rr_ptr_nxt  = r_sel;
                end else begin
                    w_det_w_nxt   = w_in[r_sel];
                end
            end

            c_ST_FLUSH: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase

        // Set has priority over clear on the same bit.
        w_hit_nxt = (r_hit & ~hit_clr) | w_hit_set;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_gnt     <= '0;
            r_det_w   <= 1'b0;
            r_det_clr <= 1'b1;   // detector held cleared during reset
            r_hit     <= '0;
            r_rr_ptr  <= c_RR_PTR_RST;
            r_sel     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_det_w   <= w_det_w_nxt;
            r_det_clr <= w_det_clr_nxt;
            r_hit     <= w_hit_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign det_w   = r_det_w;
    assign det_clr = r_det_clr;
    assign hit     = r_hit;
    assign busy    = (r_state != c_ST_IDLE);

endmodule : seq_det_arbiter
`default_nettype wire

// File: tb/tb_seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_arbiter
// Description : Self-checking bench for seq_det_arbiter (NREQ=4,
//               BURST_LEN=8). A burst-level model (owner, burst age, gap
//               countdown, last owner) predicts gnt/det_w/det_clr/hit/busy
//               every cycle; directed scenarios add literal expectations.
//               Honours SEQ_DET_ARB_FIXED_PRIO_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_arbiter;

    localparam int c_NREQ      = 4;
    localparam int c_BURST_LEN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] w_in = '0;
    logic       det_b = 1'b0;
    logic [3:0] hit_clr = '0;
    logic [3:0] gnt;
    logic       det_w;
    logic       det_clr;
    logic [3:0] hit;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    seq_det_arbiter #(
        .NREQ      (c_NREQ),
        .BURST_LEN (c_BURST_LEN),
        .CNT_W     (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .w_in    (w_in),
        .det_b   (det_b),
        .gnt     (gnt),
        .det_w   (det_w),
        .det_clr (det_clr),
        .hit     (hit),
        .hit_clr (hit_clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Burst-level model
    // ------------------------------------------------------------------
    logic       m_active;   // a requester currently owns the detector
    logic [1:0] m_own;      // its index
    int         m_age;      // RUN cycles it has completed so far
    int         m_gap;      // clear cycles still to run before arbitration
    logic [1:0] m_last;     // most recent owner
    logic [3:0] m_hit;
    logic       m_dw;
    logic       m_clr;

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] c;
        pick = 2'd0;
`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            c = 2'(k);
            if (r[c]) pick = c;
        end
`else
        // Nearest set bit after 'last', wrapping; 'last' itself is checked last.
        for (int k = 4; k >= 1; k--) begin
            c = last + 2'(k);
            if (r[c]) pick = c;
        end
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0; m_own = 2'd0; m_age = 0; m_gap = 0;
                m_last = 2'd3; m_hit = '0; m_dw = 1'b0; m_clr = 1'b1;
            end else begin
                logic [3:0] hs;
                hs = '0;
                if (m_active && m_age >= 1 && det_b) hs[m_own] = 1'b1;
                m_hit = (m_hit & ~hit_clr) | hs;
                if (m_active) begin
                    if (m_age == c_BURST_LEN - 1 || !req[m_own]) begin
                        m_last = m_own; m_active = 1'b0; m_gap = 1;
                        m_clr = 1'b1; m_dw = 1'b0;
                    end else begin
                        m_dw = w_in[m_own]; m_age++; m_clr = 1'b0;
                    end
                end else if (m_gap > 0) begin
                    m_gap--; m_clr = 1'b0; m_dw = 1'b0;
                end else begin
                    m_clr = 1'b0; m_dw = 1'b0;
                    if (req != 4'b0000) begin
                        m_own = pick(req, m_last); m_active = 1'b1; m_age = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                logic [3:0] eg;
                eg = m_active ? (4'b0001 << m_own) : 4'b0000;
                check("gnt",     32'(gnt),     32'(eg));
                check("det_w",   32'(det_w),   32'(m_dw));
                check("det_clr", 32'(det_clr), 32'(m_clr));
                check("hit",     32'(hit),     32'(m_hit));
                check("busy",    32'(busy),    32'(m_active || (m_gap > 0)));
            end
        end
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; w_in = '0; det_b = 1'b0; hit_clr = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
    localparam logic [3:0] c_E_SECOND = 4'b0001;
`else
    localparam logic [3:0] c_E_SECOND = 4'b0010;
`endif

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] order [5];
        logic [3:0] exp_order [5];
        logic [3:0] prev;
        int         n_ord;
        int         n_fix;

        // ---- Reset values and single requester ----
        do_reset();
        #1;
        check("rst_gnt",     32'(gnt),     32'h0);
        check("rst_det_clr", 32'(det_clr), 32'h1);
        check("rst_det_w",   32'(det_w),   32'h0);
        check("rst_hit",     32'(hit),     32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        req = 4'b0001;
        tick();                                   // first RUN cycle
        check("A_gnt_first", 32'(gnt), 32'h1);
        check("A_clr_low",   32'(det_clr), 32'h0);
        w_in = 4'b0001; tick();
        check("A_det_w_1", 32'(det_w), 32'h1);
        w_in = 4'b1110; tick();                   // other bits must not leak
        check("A_det_w_0", 32'(det_w), 32'h0);
        for (int k = 0; k < 6; k++) begin
            w_in = 4'((k * 11 + 5) % 16); tick();
        end
        check("A_gnt_drop", 32'(gnt),     32'h0);
        check("A_clr_set",  32'(det_clr), 32'h1);
        check("A_busy_fl",  32'(busy),    32'h1);
        tick();
        check("A_idle_clr", 32'(det_clr), 32'h0);
        check("A_idle_gnt", 32'(gnt),     32'h0);
        tick();
        check("A_regrant",  32'(gnt),     32'h1);
        for (int k = 0; k < 7; k++) begin
            w_in = 4'((k * 7 + 3) % 16); tick();
        end
        req = 4'b0000; tick();                    // drop on the final cycle
        check("A_last_drop_gnt", 32'(gnt),     32'h0);
        check("A_last_drop_clr", 32'(det_clr), 32'h1);
        tick();
        check("A_single_exit", 32'(det_clr), 32'h0);
        check("A_idle_busy",   32'(busy),    32'h0);
        tick();
        check("A_no_grant",    32'(gnt),     32'h0);

`ifndef SEQ_DET_ARB_FIXED_PRIO_EN
        // ---- All requesting: round-robin order ----
        do_reset();
        req = 4'b1111; prev = 4'b0000; n_ord = 0;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        for (int k = 0; k < 60 && n_ord < 5; k++) begin
            w_in = 4'((k * 13 + 9) % 16);
            tick();
            if (gnt != 4'b0000 && prev == 4'b0000) begin
                order[n_ord] = gnt;
                n_ord++;
            end
            prev = gnt;
        end
        check("B_grant_count", 32'(n_ord), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < n_ord) check($sformatf("B_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        end
`endif

        // ---- Early release ----
        do_reset();
        req = 4'b1100; tick();
        check("C_gnt2", 32'(gnt), 32'b0100);
        w_in = 4'b0100; tick();
        w_in = 4'b0000; tick();
        req = 4'b1000; tick();                    // dropped in RUN cycle 3
        check("C_gnt_off", 32'(gnt),     32'h0);
        check("C_clr",     32'(det_clr), 32'h1);
        tick(); tick();
        check("C_next",    32'(gnt), 32'b1000);
        req = 4'b0000; tick(); tick();

        // ---- Hit capture ----
        do_reset();
        req = 4'b0010; tick();
        det_b = 1'b1; tick();                     // first RUN cycle: ignored
        check("D_first_ignored", 32'(hit), 32'h0);
        det_b = 1'b0; tick(); tick();
        det_b = 1'b1; tick();                     // RUN cycle 4
        check("D_hit_set", 32'(hit), 32'b0010);
        det_b = 1'b0;
        repeat (4) tick();
        check("D_hit_sticky", 32'(hit), 32'b0010);
        hit_clr = 4'b0010; tick();
        hit_clr = 4'b0000;
        check("D_hit_cleared", 32'(hit), 32'h0);
        tick();
        check("D_regrant", 32'(gnt), 32'b0010);
        tick();
        det_b = 1'b1; hit_clr = 4'b0010; tick();  // set beats clear
        check("D_set_wins", 32'(hit), 32'b0010);
        det_b = 1'b0; hit_clr = 4'b0000; req = 4'b0000; tick(); tick();

        // ---- Reset mid-burst ----
        do_reset();
        req = 4'b1111;
        repeat (11) tick();                       // second burst begins
        check("E_second", 32'(gnt), 32'(c_E_SECOND));
        tick(); tick();
        det_b = 1'b1; tick();
        det_b = 1'b0;
        check("E_hit_before", 32'(hit), 32'(c_E_SECOND));
        tick();                                   // RUN cycle 5
        #2 rst = 1'b1;
        #1;
        check("E_async_gnt",  32'(gnt),     32'h0);
        check("E_async_clr",  32'(det_clr), 32'h1);
        check("E_async_hit",  32'(hit),     32'h0);
        check("E_async_busy", 32'(busy),    32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("E_clr_after_rel", 32'(det_clr), 32'h1);
        tick();
        check("E_first_after", 32'(gnt), 32'b0001);
        req = 4'b0000; repeat (9) tick();

`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
        // ---- Fixed priority ----
        do_reset();
        req = 4'b1010; n_fix = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt != 4'b0000) begin
                check("F_prio", 32'(gnt), 32'b0010);
                if (prev == 4'b0000) n_fix++;
            end
            prev = gnt;
        end
        check("F_regrants", 32'(n_fix >= 3), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_det_arbiter
`default_nettype wire
